// File: rtl/reg_scoreboard_if.sv
// ---------------------------------------------------------------------------
// reg_scoreboard_if
//   Bundles the decode-side issue request, the writeback report, the flush
//   strobe and the scoreboard's responses into one connection.
//
//   Decode / writeback side (master drives, slave observes):
//     issueValid       instruction presented this cycle
//     regRs, useRs     source register 1 and its read enable
//     regRt, useRt     source register 2 and its read enable
//     destReg          destination register
//     destValid        the instruction writes destReg
//     wbValid          writeback performs a register write this cycle
//     wbRegister       register written by writeback
//     flush            discard all pending-write state
//   Scoreboard side (slave drives, master observes):
//     stall            combinational issue block
//     issueAccept      combinational issueValid & ~stall & ~flush
//     busyVec          registered per-register pending flags
//     stallCount       registered stalled-issue cycle counter
// ---------------------------------------------------------------------------
interface reg_scoreboard_if;
  logic        issueValid;
  logic [4:0]  regRs;
  logic        useRs;
  logic [4:0]  regRt;
  logic        useRt;
  logic [4:0]  destReg;
  logic        destValid;
  logic        wbValid;
  logic [4:0]  wbRegister;
  logic        flush;
  logic        stall;
  logic        issueAccept;
  logic [31:0] busyVec;
  logic [31:0] stallCount;

  modport master (
    output issueValid, regRs, useRs, regRt, useRt, destReg, destValid,
    output wbValid, wbRegister, flush,
    input  stall, issueAccept, busyVec, stallCount
  );

  modport slave (
    input  issueValid, regRs, useRs, regRt, useRt, destReg, destValid,
    input  wbValid, wbRegister, flush,
    output stall, issueAccept, busyVec, stallCount
  );
endinterface

// File: rtl/reg_scoreboard.sv
// ---------------------------------------------------------------------------
// reg_scoreboard
//   Read-after-write hazard scoreboard for the decode stage. Keeps a
//   CNT_W-bit count of in-flight writes for each architectural register
//   1..31 (register 0 is never tracked), stalls issue while a source is
//   pending or the destination count is saturated, and counts stalled
//   issue cycles.
//
//   Ports:
//     clk   rising-edge clock
//     rstN  asynchronous active-low reset
//     sb    reg_scoreboard_if.slave (issue, writeback, flush, responses)
//
//   Parameter:
//     CNT_W  width of each pending-write counter (max 2^CNT_W-1 in flight)
//
//   Build option:
//     REG_SCOREBOARD_WAW_STALL_EN  when defined, any issue whose destination
//                                  is already pending stalls, so at most one
//                                  write per register is ever outstanding.
//
//   Internal state of interest: wb_underflow_q is a sticky flag for a
//   writeback to a register with no pending write; stall_events_q counts
//   RUN->HOLD transitions of the issue FSM.
// ---------------------------------------------------------------------------
module reg_scoreboard #(
  parameter int CNT_W = 2
) (
  input logic            clk,
  input logic            rstN,
  reg_scoreboard_if.slave sb
);

  typedef enum logic {RUN = 1'b0, HOLD = 1'b1} state_e;

  // Entry 0 is held at zero so register 0 reads as never pending; its flop
  // is constant and optimises away.
  logic [CNT_W-1:0] pend_q [32];
  logic [CNT_W-1:0] pend_d [32];
  logic [31:0]      busy_q,         busy_d;
  logic [31:0]      stall_count_q,  stall_count_d;
  logic [15:0]      stall_events_q, stall_events_d;
  logic             wb_underflow_q, wb_underflow_d;
  state_e           state_q,        state_d;

  logic raw_rs, raw_rt, sat, stall, issue_accept;
  logic inc, dec;

  assign raw_rs = sb.useRs && (sb.regRs != 5'd0) && (pend_q[sb.regRs] != '0);
  assign raw_rt = sb.useRt && (sb.regRt != 5'd0) && (pend_q[sb.regRt] != '0);
`ifdef REG_SCOREBOARD_WAW_STALL_EN
  assign sat = sb.destValid && (sb.destReg != 5'd0) && (pend_q[sb.destReg] != '0);
`else
  assign sat = sb.destValid && (sb.destReg != 5'd0) && (pend_q[sb.destReg] == '1);
`endif

  // No writeback bypass: a same-cycle writeback of the hazarding register
  // only lowers the count at the edge, so the stall releases a cycle later.
  assign stall        = sb.issueValid && (raw_rs || raw_rt || sat);
  assign issue_accept = sb.issueValid && !stall && !sb.flush;

  assign sb.stall       = stall;
  assign sb.issueAccept = issue_accept;
  assign sb.busyVec     = busy_q;
  assign sb.stallCount  = stall_count_q;

  // Pending-count update. Saturation stalls the issue, so an increment can
  // never wrap a full counter.
  always_comb begin
    // NOTE: every variable gets a default before any branch, so no path can
    // leave one unassigned and infer a latch.
    pend_d         = pend_q;
    busy_d         = '0;
    wb_underflow_d = wb_underflow_q;
    inc            = 1'b0;
    dec            = 1'b0;
    pend_d[0]      = '0;
    for (int r = 1; r < 32; r++) begin
      inc = issue_accept && sb.destValid && (sb.destReg == 5'(r));
      dec = sb.wbValid && (sb.wbRegister == 5'(r));
      if (sb.flush) begin
        pend_d[r] = '0;
      end else if (inc && !dec) begin
        pend_d[r] = pend_q[r] + 1'b1;
      end else if (dec && !inc) begin
        if (pend_q[r] != '0) pend_d[r] = pend_q[r] - 1'b1;
        else                 wb_underflow_d = 1'b1;
      end
      busy_d[r] = (pend_d[r] != '0);
    end
  end

  // A stalled issue in a flush cycle is discarded, not counted.
  assign stall_count_d = stall_count_q + 32'(stall && !sb.flush);

  // Issue FSM: only qualifies the stall-event statistic.
  always_comb begin
    state_d        = state_q;
    stall_events_d = stall_events_q;
    case (state_q)
      RUN: begin
        if (stall) begin
          state_d        = HOLD;
          stall_events_d = stall_events_q + 16'd1;
        end
      end
      HOLD: begin
        if (!stall || sb.flush) state_d = RUN;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge value of every other flop.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      // NOTE: the count array is reset explicitly: a reset mid-stall must
      // clear every pending write, which releases the stall at once.
      for (int r = 0; r < 32; r++) pend_q[r] <= '0;
      busy_q         <= '0;
      stall_count_q  <= '0;
      stall_events_q <= '0;
      wb_underflow_q <= 1'b0;
      state_q        <= RUN;
    end else begin
      pend_q         <= pend_d;
      busy_q         <= busy_d;
      stall_count_q  <= stall_count_d;
      stall_events_q <= stall_events_d;
      wb_underflow_q <= wb_underflow_d;
      state_q        <= state_d;
    end
  end

endmodule

// File: tb/tb_reg_scoreboard.sv
// ---------------------------------------------------------------------------
// tb_reg_scoreboard
//   Directed scenarios followed by randomized traffic, all checked against a
//   behavioural model: an integer count of in-flight writes per register, a
//   stall rule phrased as "a source is in flight or the destination has no
//   room left", and plain integer counters for the statistics.
// ---------------------------------------------------------------------------
module tb_reg_scoreboard;

`ifdef REG_SCOREBOARD_WAW_STALL_EN
  localparam int LIMIT = 1;
`else
  localparam int LIMIT = 3;
`endif

  logic clk = 1'b0;
  logic rstN;
  always #5 clk = ~clk;

  reg_scoreboard_if sb ();

  reg_scoreboard #(.CNT_W(2)) dut (
    .clk  (clk),
    .rstN (rstN),
    .sb   (sb)
  );

  int          n_checks = 0;
  int          n_errors = 0;

  int          m_pend [32];
  int unsigned m_stall_cnt;
  int unsigned m_events;
  bit          m_uflow;
  bit          m_hold;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int r = 0; r < 32; r++) m_pend[r] = 0;
    m_stall_cnt = 0;
    m_events    = 0;
    m_uflow     = 1'b0;
    m_hold      = 1'b0;
  endtask

  function automatic bit model_stall();
    bit hz = 1'b0;
    if (sb.useRs && sb.regRs != 0 && m_pend[sb.regRs] > 0) hz = 1'b1;
    if (sb.useRt && sb.regRt != 0 && m_pend[sb.regRt] > 0) hz = 1'b1;
    if (sb.destValid && sb.destReg != 0 && m_pend[sb.destReg] >= LIMIT) hz = 1'b1;
    return sb.issueValid && hz;
  endfunction

  function automatic logic [31:0] model_busy();
    logic [31:0] v = '0;
    for (int r = 1; r < 32; r++) v[r] = (m_pend[r] > 0);
    return v;
  endfunction

  task automatic idle();
    sb.issueValid = 0; sb.regRs = 0; sb.useRs = 0; sb.regRt = 0; sb.useRt = 0;
    sb.destReg = 0; sb.destValid = 0; sb.wbValid = 0; sb.wbRegister = 0; sb.flush = 0;
  endtask

  task automatic issue(input int dst, input bit dv, input int rs, input bit urs);
    sb.issueValid = 1; sb.destReg = 5'(dst); sb.destValid = dv;
    sb.regRs = 5'(rs); sb.useRs = urs; sb.regRt = 0; sb.useRt = 0;
  endtask

  // Called just after a falling edge with inputs already applied; checks the
  // combinational outputs, advances the model, crosses one rising edge and
  // checks the registered outputs, then returns at the next falling edge.
  task automatic tick(input string tag);
    bit es, ea;
    #1;
    es = model_stall();
    ea = sb.issueValid && !es && !sb.flush;
    check({tag, ":stall"}, 32'(sb.stall), 32'(es));
    check({tag, ":accept"}, 32'(sb.issueAccept), 32'(ea));
    if (sb.flush) begin
      for (int r = 0; r < 32; r++) m_pend[r] = 0;
    end else begin
      for (int r = 1; r < 32; r++) begin
        int delta = 0;
        if (ea && sb.destValid && sb.destReg == r) delta++;
        if (sb.wbValid && sb.wbRegister == r) delta--;
        if (m_pend[r] + delta < 0) m_uflow = 1'b1;
        else m_pend[r] += delta;
      end
    end
    if (es && !sb.flush) m_stall_cnt++;
    if (!m_hold) begin
      if (es) begin m_hold = 1'b1; m_events++; end
    end else if (!es || sb.flush) begin
      m_hold = 1'b0;
    end
    @(posedge clk);
    #1;
    check({tag, ":busyVec"}, sb.busyVec, model_busy());
    check({tag, ":stallCount"}, sb.stallCount, m_stall_cnt);
    check({tag, ":wbUnderflow"}, 32'(dut.wb_underflow_q), 32'(m_uflow));
    @(negedge clk);
  endtask

  initial begin
    idle();
    model_reset();
    rstN = 1'b0;
    #12;
    check("rst:busyVec", sb.busyVec, 32'h0);
    check("rst:stallCount", sb.stallCount, 32'h0);
    check("rst:stall", 32'(sb.stall), 32'h0);
    check("rst:wbUnderflow", 32'(dut.wb_underflow_q), 32'h0);
    check("rst:stallEvents", 32'(dut.stall_events_q), 32'h0);
    @(negedge clk);
    rstN = 1'b1;
    @(negedge clk);

    // RAW on register 5, released one cycle after its writeback.
    issue(5, 1, 0, 0);
    tick("iss5");
    check("iss5:busy20", sb.busyVec, 32'h0000_0020);
    issue(0, 0, 5, 1);
    tick("raw5a");
    tick("raw5b");
    sb.wbValid = 1; sb.wbRegister = 5;
    tick("raw5_wb_same");
    sb.wbValid = 0;
    tick("rel5");
    check("rel5:count3", sb.stallCount, 32'd3);

    // Register 0 is never tracked.
    issue(0, 1, 0, 1);
    sb.regRt = 0; sb.useRt = 1;
    tick("r0");
    check("r0:busy0", sb.busyVec, 32'h0);

    // Same-cycle issue and writeback of register 7 leaves the count alone.
    issue(7, 1, 0, 0);
    tick("iss7");
    sb.wbValid = 1; sb.wbRegister = 7;
    tick("iss7_wb7");
    check("iss7_wb7:bit7", 32'(sb.busyVec[7]), 32'h1);
    idle();
    sb.wbValid = 1; sb.wbRegister = 7;
    tick("wb7");

    // Saturation of register 9.
    idle();
    issue(9, 1, 0, 0);
    tick("iss9a");
`ifdef REG_SCOREBOARD_WAW_STALL_EN
    #1 check("iss9b:waw_stall", 32'(sb.stall), 32'h1);
`endif
    tick("iss9b");
    tick("iss9c");
    #1 check("iss9d:sat_stall", 32'(sb.stall), 32'h1);
    tick("iss9d");
    idle();
    while (m_pend[9] > 0) begin
      sb.wbValid = 1; sb.wbRegister = 9;
      tick("drain9");
    end

    // Flush beats same-cycle writeback and issue; a later writeback underflows.
    idle();
    issue(3, 1, 0, 0);
    tick("iss3");
    issue(4, 1, 0, 0);
    tick("iss4");
    issue(8, 1, 0, 0);
    sb.wbValid = 1; sb.wbRegister = 3; sb.flush = 1;
    tick("flush");
    check("flush:busy0", sb.busyVec, 32'h0);
    idle();
    sb.wbValid = 1; sb.wbRegister = 3;
    tick("spur3");
    check("spur3:uflow", 32'(dut.wb_underflow_q), 32'h1);

    // Reset in the middle of a stall releases it without a clock edge.
    idle();
    issue(10, 1, 0, 0);
    tick("iss10");
    issue(0, 0, 10, 1);
    #1 check("pre_rst:stall", 32'(sb.stall), 32'h1);
    rstN = 1'b0;
    #1;
    check("mid_rst:stall", 32'(sb.stall), 32'h0);
    check("mid_rst:stallCount", sb.stallCount, 32'h0);
    check("mid_rst:busyVec", sb.busyVec, 32'h0);
    model_reset();
    idle();
    #1 rstN = 1'b1;
    @(negedge clk);

    // Randomized traffic on a small register window to provoke hazards.
    for (int i = 0; i < 400; i++) begin
      idle();
      sb.issueValid = ($urandom_range(0, 9) < 7);
      sb.regRs      = 5'($urandom_range(0, 7));
      sb.useRs      = 1'($urandom_range(0, 1));
      sb.regRt      = 5'($urandom_range(0, 7));
      sb.useRt      = 1'($urandom_range(0, 1));
      sb.destReg    = 5'($urandom_range(0, 7));
      sb.destValid  = ($urandom_range(0, 9) < 6);
      sb.flush      = ($urandom_range(0, 99) < 3);
      if ($urandom_range(0, 9) < 5) begin
        int pick = $urandom_range(1, 7);
        sb.wbValid = 1;
        sb.wbRegister = 5'(pick);
        if ($urandom_range(0, 9) != 0) begin
          for (int k = 0; k < 7; k++) begin
            int r = 1 + ((pick - 1 + k) % 7);
            if (m_pend[r] > 0) begin sb.wbRegister = 5'(r); break; end
          end
        end
      end
      tick("rand");
    end
    check("end:stallEvents", 32'(dut.stall_events_q), 32'(m_events[15:0]));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
